// File: rtl/palette_layer_mapper_if.sv
// ---------------------------------------------------------------------------
// palette_layer_mapper_if
//   Bundles the pixel, palette-programming and RGB output signals of the
//   palette_layer_mapper so that the fetch side and the VGA side connect with
//   a single port.
//
//   Pixel side   : pix_valid, blank_n, layer_idx, shift
//   Palette side : pal_we, pal_waddr, pal_wdata, bg_we, bg_wdata
//   Output side  : Red, Green, Blue, rgb_valid
//
//   master modport : the sprite/tile fetch logic (drives pixels and palette
//                    writes, observes RGB)
//   slave modport  : the mapper itself
// ---------------------------------------------------------------------------
interface palette_layer_mapper_if #(
  parameter int IDX_W      = 6,
  parameter int NUM_LAYERS = 3
);
  logic                          pix_valid;
  logic                          blank_n;
  logic [NUM_LAYERS*IDX_W-1:0]   layer_idx;
  logic                          pal_we;
  logic [IDX_W-1:0]              pal_waddr;
  logic [23:0]                   pal_wdata;
  logic                          bg_we;
  logic [23:0]                   bg_wdata;
  logic [1:0]                    shift;
  logic [7:0]                    Red;
  logic [7:0]                    Green;
  logic [7:0]                    Blue;
  logic                          rgb_valid;

  modport master (
    output pix_valid, blank_n, layer_idx, pal_we, pal_waddr, pal_wdata,
           bg_we, bg_wdata, shift,
    input  Red, Green, Blue, rgb_valid
  );

  modport slave (
    input  pix_valid, blank_n, layer_idx, pal_we, pal_waddr, pal_wdata,
           bg_we, bg_wdata, shift,
    output Red, Green, Blue, rgb_valid
  );
endinterface

// File: rtl/palette_layer_mapper.sv
// ---------------------------------------------------------------------------
// palette_layer_mapper
//   Resolves one pixel from NUM_LAYERS stacked palette indices (layer 0 wins),
//   looks the winning index up in a programmable palette, then applies
//   blanking and a brightness shift. Three-stage pipeline, no stall:
//     S1 : priority select of the first non-transparent layer
//     S2 : palette / background lookup with write-through bypass
//     S3 : blanking + brightness shift, registered RGB out
//
//   Ports
//     Clk      : system clock, rising edge
//     Reset_n  : asynchronous active-low reset
//     bus      : palette_layer_mapper_if.slave (pixel inputs, palette and
//                background writes, registered RGB outputs)
// ---------------------------------------------------------------------------
module palette_layer_mapper #(
  parameter int          IDX_W      = 6,
  parameter int          NUM_LAYERS = 3,
  parameter logic [23:0] BG_DEFAULT = 24'h3BB9FF
) (
  input  logic                  Clk,
  input  logic                  Reset_n,
  palette_layer_mapper_if.slave bus
);

  localparam int PAL_DEPTH = 1 << IDX_W;

  // S1 state
  logic             r_s1_valid;
  logic             r_s1_hit;
  logic [IDX_W-1:0] r_s1_sel;
  logic             r_s1_blank_n;

  // Palette storage and background colour
  logic [23:0]      r_pal [PAL_DEPTH];
  logic [23:0]      r_bg;

  // S2 state
  logic             r_s2_valid;
  logic             r_s2_blank_n;
  logic [23:0]      r_s2_colour;

  // S3 / output state
  logic [7:0]       r_red;
  logic [7:0]       r_green;
  logic [7:0]       r_blue;
  logic             r_rgb_valid;

  // Combinational intermediates
  logic [IDX_W-1:0] w_sel;
  logic             w_hit;
  logic [23:0]      w_pal_rd;
  logic [23:0]      w_bg_rd;
  logic [23:0]      w_colour;

  // Scanning from the lowest-priority layer upwards lets the last
  // assignment win, so the lowest-numbered non-zero layer ends up selected.
  always_comb begin
    w_sel = '0;
    w_hit = 1'b0;
    for (int k = NUM_LAYERS - 1; k >= 0; k--) begin
      if (bus.layer_idx[k*IDX_W +: IDX_W] != '0) begin
        w_sel = bus.layer_idx[k*IDX_W +: IDX_W];
        w_hit = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s1_valid   <= 1'b0;
      r_s1_hit     <= 1'b0;
      r_s1_sel     <= '0;
      r_s1_blank_n <= 1'b0;
    end else begin
      r_s1_valid   <= bus.pix_valid;
      r_s1_hit     <= w_hit;
      r_s1_sel     <= w_sel;
      r_s1_blank_n <= bus.blank_n;
    end
  end

  // The palette must come out of reset all-black, so every entry is cleared.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < PAL_DEPTH; i++) begin
        r_pal[i] <= '0;
      end
    end else if (bus.pal_we) begin
      r_pal[bus.pal_waddr] <= bus.pal_wdata;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_bg <= BG_DEFAULT;
    end else if (bus.bg_we) begin
      r_bg <= bus.bg_wdata;
    end
  end

  // A write landing in the same cycle as the lookup is forwarded, so the
  // pixel sees the colour being written rather than the stale entry.
  always_comb begin
    w_pal_rd = r_pal[r_s1_sel];
    if (bus.pal_we && (bus.pal_waddr == r_s1_sel)) begin
      w_pal_rd = bus.pal_wdata;
    end
    w_bg_rd  = bus.bg_we ? bus.bg_wdata : r_bg;
    w_colour = r_s1_hit ? w_pal_rd : w_bg_rd;
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_s2_valid   <= 1'b0;
      r_s2_blank_n <= 1'b0;
      r_s2_colour  <= '0;
    end else begin
      r_s2_valid   <= r_s1_valid;
      r_s2_blank_n <= r_s1_blank_n;
      r_s2_colour  <= w_colour;
    end
  end

  // Outputs only move on a valid pixel; otherwise the last colour is held.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_red       <= '0;
      r_green     <= '0;
      r_blue      <= '0;
      r_rgb_valid <= 1'b0;
    end else begin
      r_rgb_valid <= r_s2_valid;
      if (r_s2_valid) begin
        r_red   <= r_s2_blank_n ? (r_s2_colour[23:16] >> bus.shift) : 8'h00;
        r_green <= r_s2_blank_n ? (r_s2_colour[15:8]  >> bus.shift) : 8'h00;
        r_blue  <= r_s2_blank_n ? (r_s2_colour[7:0]   >> bus.shift) : 8'h00;
      end
    end
  end

  assign bus.Red       = r_red;
  assign bus.Green     = r_green;
  assign bus.Blue      = r_blue;
  assign bus.rgb_valid = r_rgb_valid;

endmodule

// File: tb/tb_palette_layer_mapper.sv
// ---------------------------------------------------------------------------
// tb_palette_layer_mapper
//   Drives directed and random pixels / palette writes into the mapper.
//   A cycle-history reference model computes each pixel's colour from the
//   inputs seen on its sample cycle, the lookup cycle and the output cycle,
//   and pushes the result into a queue; a negedge monitor pops and compares.
// ---------------------------------------------------------------------------
module tb_palette_layer_mapper;

  localparam int IDX_W = 6;
  localparam int NL    = 3;
  localparam int HSZ   = 4096;

  logic clk;
  logic rst_n;

  palette_layer_mapper_if #(.IDX_W(IDX_W), .NUM_LAYERS(NL)) bus ();

  palette_layer_mapper #(
    .IDX_W      (IDX_W),
    .NUM_LAYERS (NL),
    .BG_DEFAULT (24'h3BB9FF)
  ) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [23:0] mPal [64];
  logic [23:0] mBg;
  logic        histPv     [HSZ];
  logic [17:0] histLayers [HSZ];
  logic        histBlank  [HSZ];
  logic [23:0] colourOf   [HSZ];
  int          cyc = 2;
  logic [23:0] expQ [$];
  logic [23:0] lastExp = 24'h0;

  logic [1:0]  curShift = 2'd0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: each pixel takes its layers/blank from its sample cycle,
  // its colour from the palette as written up to and including the following
  // cycle, and its shift from the cycle after that.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 64; i++) mPal[i] = 24'h0;
      mBg = 24'h3BB9FF;
      histPv[(cyc-1) % HSZ] = 1'b0;
      histPv[(cyc-2) % HSZ] = 1'b0;
      expQ.delete();
      lastExp = 24'h0;
    end else begin
      int c;
      c = cyc % HSZ;
      histPv[c]     = bus.pix_valid;
      histLayers[c] = bus.layer_idx;
      histBlank[c]  = bus.blank_n;
      if (bus.pal_we) mPal[bus.pal_waddr] = bus.pal_wdata;
      if (bus.bg_we)  mBg = bus.bg_wdata;
      if (histPv[(cyc-1) % HSZ]) begin
        logic [17:0] l;
        logic        found;
        l = histLayers[(cyc-1) % HSZ];
        found = 1'b0;
        colourOf[(cyc-1) % HSZ] = mBg;
        for (int k = 0; k < NL; k++) begin
          if (!found && l[k*IDX_W +: IDX_W] != 6'd0) begin
            found = 1'b1;
            colourOf[(cyc-1) % HSZ] = mPal[l[k*IDX_W +: IDX_W]];
          end
        end
      end
      if (histPv[(cyc-2) % HSZ]) begin
        logic [23:0] col;
        logic [7:0]  r, g, b;
        col = colourOf[(cyc-2) % HSZ];
        r = col[23:16] >> bus.shift;
        g = col[15:8]  >> bus.shift;
        b = col[7:0]   >> bus.shift;
        if (!histBlank[(cyc-2) % HSZ]) begin
          r = 8'h0; g = 8'h0; b = 8'h0;
        end
        expQ.push_back({r, g, b});
      end
      cyc = cyc + 1;
    end
  end

  // Monitor: every cycle out of reset, rgb_valid must match the model, a
  // valid pixel must match the queued colour, and idle cycles must hold.
  always @(negedge clk) begin
    if (rst_n) begin
      logic expValid;
      logic [23:0] act;
      expValid = (expQ.size() > 0);
      act = {bus.Red, bus.Green, bus.Blue};
      checks++;
      if (bus.rgb_valid !== expValid) begin
        errors++;
        $display("[TB] FAIL rgbValid at %0t: got %b expected %b", $time, bus.rgb_valid, expValid);
      end
      if (expValid) begin
        logic [23:0] e;
        e = expQ.pop_front();
        checks++;
        if (act !== e) begin
          errors++;
          $display("[TB] FAIL pixelColour at %0t: got %h expected %h", $time, act, e);
        end
        lastExp = e;
      end else begin
        checks++;
        if (act !== lastExp) begin
          errors++;
          $display("[TB] FAIL holdColour at %0t: got %h expected %h", $time, act, lastExp);
        end
      end
    end
  end

  task automatic applyStimulus(input logic pv, input logic [17:0] layers, input logic blank,
                               input logic pwe, input logic [5:0] waddr, input logic [23:0] wdata,
                               input logic bwe, input logic [23:0] bdata, input logic [1:0] sh);
    bus.pix_valid = pv;
    bus.layer_idx = layers;
    bus.blank_n   = blank;
    bus.pal_we    = pwe;
    bus.pal_waddr = waddr;
    bus.pal_wdata = wdata;
    bus.bg_we     = bwe;
    bus.bg_wdata  = bdata;
    bus.shift     = sh;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 18'h0, 1'b1, 1'b0, 6'd0, 24'h0, 1'b0, 24'h0, curShift);
  endtask

  task automatic pixel(input logic [17:0] layers, input logic blank);
    applyStimulus(1'b1, layers, blank, 1'b0, 6'd0, 24'h0, 1'b0, 24'h0, curShift);
  endtask

  task automatic writePal(input logic [5:0] addr, input logic [23:0] data);
    applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, addr, data, 1'b0, 24'h0, curShift);
  endtask

  task automatic checkOutput(input string name, input logic [23:0] expRgb, input logic expValid);
    checks++;
    if ({bus.Red, bus.Green, bus.Blue} !== expRgb || bus.rgb_valid !== expValid) begin
      errors++;
      $display("[TB] FAIL %s: got rgb=%h valid=%b expected rgb=%h valid=%b",
               name, {bus.Red, bus.Green, bus.Blue}, bus.rgb_valid, expRgb, expValid);
    end
  endtask

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog expired: got timeout expected finish");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [17:0] l;
    logic [5:0]  a;
    rst_n = 1'b0;
    bus.pix_valid = 1'b0; bus.layer_idx = '0; bus.blank_n = 1'b1;
    bus.pal_we = 1'b0; bus.pal_waddr = '0; bus.pal_wdata = '0;
    bus.bg_we = 1'b0; bus.bg_wdata = '0; bus.shift = '0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetState", 24'h000000, 1'b0);
    rst_n = 1'b1;

    // Background colour straight out of reset
    pixel(18'h0, 1'b1); idle(); idle();
    checkOutput("bgDefault", 24'h3BB9FF, 1'b1);

    // Priority between layers
    writePal(6'd5, 24'hFF5500);
    writePal(6'd9, 24'h00F000);
    pixel({6'd9, 6'd5, 6'd0}, 1'b1); idle(); idle();
    checkOutput("prioL1", 24'hFF5500, 1'b1);
    pixel({6'd0, 6'd5, 6'd9}, 1'b1); idle(); idle();
    checkOutput("prioL0", 24'h00F000, 1'b1);

    // Write-through bypass during the lookup cycle
    pixel({6'd0, 6'd0, 6'd5}, 1'b1);
    applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 6'd5, 24'h123456, 1'b0, 24'h0, curShift);
    idle();
    checkOutput("bypassHit", 24'h123456, 1'b1);
    writePal(6'd5, 24'hFF5500);
    pixel({6'd0, 6'd0, 6'd5}, 1'b1);
    applyStimulus(1'b0, 18'h0, 1'b1, 1'b1, 6'd6, 24'h123456, 1'b0, 24'h0, curShift);
    idle();
    checkOutput("bypassMiss", 24'hFF5500, 1'b1);

    // Brightness shift and blanking
    curShift = 2'd2;
    pixel({6'd0, 6'd0, 6'd5}, 1'b1); idle(); idle();
    checkOutput("shift2", 24'h3F1500, 1'b1);
    pixel({6'd0, 6'd0, 6'd5}, 1'b0); idle(); idle();
    checkOutput("blanked", 24'h000000, 1'b1);
    curShift = 2'd0;

    // Alternating pixel valid
    for (int i = 0; i < 4; i++) begin
      pixel({6'd0, 6'd0, (i % 2 == 0) ? 6'd5 : 6'd9}, 1'b1);
      idle();
    end
    idle(); idle();

    // Reset with two pixels in flight
    pixel({6'd0, 6'd0, 6'd5}, 1'b1);
    pixel({6'd0, 6'd0, 6'd9}, 1'b1);
    bus.pix_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checkOutput("resetMidFrame", 24'h000000, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (4) idle();
    checkOutput("noPulseAfterReset", 24'h000000, 1'b0);
    pixel({6'd0, 6'd0, 6'd5}, 1'b1); idle(); idle();
    checkOutput("palCleared", 24'h000000, 1'b1);
    pixel(18'h0, 1'b1); idle(); idle();
    checkOutput("bgRestored", 24'h3BB9FF, 1'b1);

    // Random traffic, with small address ranges so bypass collisions happen
    for (int i = 0; i < 800; i++) begin
      for (int k = 0; k < NL; k++) begin
        l[k*IDX_W +: IDX_W] = ($urandom_range(0, 1) == 0) ? 6'd0 : 6'($urandom_range(1, 15));
      end
      a = 6'($urandom_range(0, 15));
      applyStimulus(($urandom_range(0, 3) != 0), l, ($urandom_range(0, 7) != 0),
                    ($urandom_range(0, 2) == 0), a, 24'($urandom),
                    ($urandom_range(0, 15) == 0), 24'($urandom),
                    2'($urandom_range(0, 3)));
    end
    repeat (5) idle();

    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: got %0d pending expected 0", expQ.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
